// File: rtl/vlb_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : vlb_mem_arb_if
// Description : Bundles the requester-side and memory-side channels that are
//               shared between the VLB refill walkers, the memory arbiter and
//               the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface vlb_mem_arb_if #(
    parameter int N     = 4,
    parameter int MCN_W = 58
);
    logic [N-1:0]       req_i_valid;
    logic [N-1:0]       req_i_ready;
    logic [N*MCN_W-1:0] req_i_bits_mcn;
    logic [N-1:0]       kill_i;
    logic [N-1:0]       resp_o_valid;
    logic [511:0]       resp_o_bits_data;
    logic               mem_req_o_valid;
    logic               mem_req_o_ready;
    logic [MCN_W-1:0]   mem_req_o_bits_mcn;
    logic               mem_resp_i_valid;
    logic               mem_resp_i_ready;
    logic [511:0]       mem_resp_i_bits_data;
    logic               busy_o;

    // Arbiter side
    modport slave (
        input  req_i_valid, req_i_bits_mcn, kill_i,
        input  mem_req_o_ready, mem_resp_i_valid, mem_resp_i_bits_data,
        output req_i_ready, resp_o_valid, resp_o_bits_data,
        output mem_req_o_valid, mem_req_o_bits_mcn, mem_resp_i_ready, busy_o
    );

    // Requester / memory side
    modport master (
        output req_i_valid, req_i_bits_mcn, kill_i,
        output mem_req_o_ready, mem_resp_i_valid, mem_resp_i_bits_data,
        input  req_i_ready, resp_o_valid, resp_o_bits_data,
        input  mem_req_o_valid, mem_req_o_bits_mcn, mem_resp_i_ready, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/vlb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : vlb_mem_arb
// Description : Round-robin arbiter for VLB line fetches onto one memory
//               request port, with an in-order owner FIFO that steers each
//               response beat back to its requester and drops killed fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module vlb_mem_arb #(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int MCN_W = 58
) (
    input  logic         clk,
    input  logic         rst_n,
    vlb_mem_arb_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    logic [N-1:0]       pending;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   fifo_owner [DEPTH];
    logic [DEPTH-1:0]   fifo_killed;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [N-1:0]       resp_valid;
    logic [511:0]       resp_data;

    logic [N-1:0]       eligible;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   next_rr;
    logic               any_eligible;
    logic               full;
    logic               req_valid;
    logic               fire;
    logic [IDX_W-1:0]   head_owner;
    logic               pop;
    logic               deliver;
    logic [DEPTH-1:0]   occupied;
    logic [AW-1:0]      slot_off;

    // Index reached by stepping 'off' positions from the round-robin pointer
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    assign eligible = bus.req_i_valid & ~pending & ~bus.kill_i;

    // Round-robin search; scanning from the far end lets the closest hit win
    always_comb begin
        grant        = '0;
        any_eligible = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[rot_idx(rr_ptr, i)]) begin
                grant        = rot_idx(rr_ptr, i);
                any_eligible = 1'b1;
            end
        end
    end

    assign next_rr    = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
    assign full       = (count == CNT_W'(DEPTH));
    assign req_valid  = any_eligible & ~full;
    assign fire       = req_valid & bus.mem_req_o_ready;
    assign head_owner = fifo_owner[rd_ptr];
    assign pop        = bus.mem_resp_i_valid & (count != '0);
    assign deliver    = pop & ~fifo_killed[rd_ptr] & ~bus.kill_i[head_owner];

    // Marks which FIFO slots hold a live fetch, counted from the read pointer
    always_comb begin
        occupied = '0;
        slot_off = '0;
        for (int j = 0; j < DEPTH; j++) begin
            slot_off    = AW'(j) - rd_ptr;
            occupied[j] = (CNT_W'(slot_off) < count);
        end
    end

    assign bus.mem_req_o_valid    = req_valid;
    assign bus.mem_req_o_bits_mcn = bus.req_i_bits_mcn[int'(grant)*MCN_W +: MCN_W];
    assign bus.req_i_ready        = fire ? (N'(1) << grant) : '0;
    assign bus.mem_resp_i_ready   = 1'b1;
    assign bus.resp_o_valid       = resp_valid;
    assign bus.resp_o_bits_data   = resp_data;
    assign bus.busy_o             = (count != '0) | (|resp_valid);

    // Grant bookkeeping, owner FIFO maintenance and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            fifo_killed <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                fifo_owner[j] <= '0;
            end
        end else begin
            // A requester is never both popped and granted in one cycle,
            // since a grant needs its pending bit to be clear already.
            pending <= (pending & ~(pop ? (N'(1) << head_owner) : '0))
                     | (fire ? (N'(1) << grant) : '0);
            count   <= count + CNT_W'(fire) - CNT_W'(pop);
            if (fire) begin
                rr_ptr <= next_rr;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            for (int j = 0; j < DEPTH; j++) begin
                if (occupied[j] && bus.kill_i[fifo_owner[j]]) begin
                    fifo_killed[j] <= 1'b1;
                end
            end
            // The write slot is free, so this never collides with a kill mark
            if (fire) begin
                fifo_owner[wr_ptr]  <= grant;
                fifo_killed[wr_ptr] <= 1'b0;
            end
            resp_valid <= deliver ? (N'(1) << head_owner) : '0;
            if (deliver) begin
                resp_data <= bus.mem_resp_i_bits_data;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vlb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vlb_mem_arb
// Description : Self-checking bench for vlb_mem_arb: directed vector table,
//               asynchronous reset sequence and randomized traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vlb_mem_arb;
    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int MCN_W = 58;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vlb_mem_arb_if #(.N(N), .MCN_W(MCN_W)) bus ();

    vlb_mem_arb #(.N(N), .DEPTH(DEPTH), .MCN_W(MCN_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] rv;
        logic [7:0] kill;
        logic       mr;
        logic       rsp;
        logic [7:0] d;
        logic [7:0] e_ready;
        logic       e_mv;
        int         e_grant;
        logic [7:0] e_rv;
        logic [7:0] e_d;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int             q_own[$];
    bit             q_kill[$];
    bit [N-1:0]     m_pend;
    int             m_rr;
    logic [N-1:0]   m_rv;
    logic [511:0]   m_rd;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] rv, input logic [7:0] kill,
                                input logic mr, input logic rsp, input logic [7:0] d,
                                input logic [7:0] er, input logic emv, input int eg,
                                input logic [7:0] erv, input logic [7:0] ed, input logic eb);
        vec_t v;
        v.rv = rv; v.kill = kill; v.mr = mr; v.rsp = rsp; v.d = d;
        v.e_ready = er; v.e_mv = emv; v.e_grant = eg; v.e_rv = erv; v.e_d = ed; v.e_busy = eb;
        return v;
    endfunction

    task automatic drive_idle();
        bus.req_i_valid          = '0;
        bus.kill_i               = '0;
        bus.mem_req_o_ready      = 1'b0;
        bus.mem_resp_i_valid     = 1'b0;
        bus.mem_resp_i_bits_data = '0;
    endtask

    task automatic set_fixed_mcn();
        for (int k = 0; k < N; k++) begin
            bus.req_i_bits_mcn[k*MCN_W +: MCN_W] = MCN_W'(32'h100 + k);
        end
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q_own.delete();
        q_kill.delete();
        m_pend = '0;
        m_rr   = 0;
        m_rv   = '0;
        m_rd   = '0;
    endtask

    // Compare this cycle against the model, then advance the model by one clock
    task automatic model_cycle();
        int           g;
        int           k;
        int           o;
        bit           kd;
        bit           e_mv;
        logic [N-1:0] e_ready;
        @(negedge clk);
        g = -1;
        for (int i = 0; i < N; i++) begin
            k = (m_rr + i) % N;
            if (g < 0 && bus.req_i_valid[k] && !m_pend[k] && !bus.kill_i[k]) g = k;
        end
        e_mv    = (g >= 0) && (q_own.size() < DEPTH);
        e_ready = (e_mv && bus.mem_req_o_ready) ? (N'(1) << g) : '0;
        check("rnd_mem_valid", 512'(bus.mem_req_o_valid), 512'(e_mv));
        check("rnd_req_ready", 512'(bus.req_i_ready), 512'(e_ready));
        if (e_mv) check("rnd_mcn", 512'(bus.mem_req_o_bits_mcn), 512'(bus.req_i_bits_mcn[g*MCN_W +: MCN_W]));
        check("rnd_resp_valid", 512'(bus.resp_o_valid), 512'(m_rv));
        check("rnd_resp_data", bus.resp_o_bits_data, m_rd);
        check("rnd_busy", 512'(bus.busy_o), 512'((q_own.size() != 0) || (m_rv != '0)));
        for (int i = 0; i < q_own.size(); i++) begin
            if (bus.kill_i[q_own[i]]) q_kill[i] = 1'b1;
        end
        m_rv = '0;
        if (bus.mem_resp_i_valid && q_own.size() > 0) begin
            o  = q_own.pop_front();
            kd = q_kill.pop_front();
            m_pend[o] = 1'b0;
            if (!kd && !bus.kill_i[o]) begin
                m_rv = N'(1) << o;
                m_rd = bus.mem_resp_i_bits_data;
            end
        end
        if (e_mv && bus.mem_req_o_ready) begin
            q_own.push_back(g);
            q_kill.push_back(1'b0);
            m_pend[g] = 1'b1;
            m_rr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        drive_idle();
        set_fixed_mcn();
        do_reset();

        //         rv     kill   mr  rsp d       ready  mv grant  rv     d      busy
        tbl.push_back(mk(8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0)); // reset state
        tbl.push_back(mk(8'h0F, 8'h00, 1, 0, 8'h00, 8'h01, 1, 0, 8'h00, 8'h00, 0)); // rr grant 0
        tbl.push_back(mk(8'h0F, 8'h00, 1, 0, 8'h00, 8'h02, 1, 1, 8'h00, 8'h00, 1));
        tbl.push_back(mk(8'h0F, 8'h00, 1, 0, 8'h00, 8'h04, 1, 2, 8'h00, 8'h00, 1));
        tbl.push_back(mk(8'h0F, 8'h00, 1, 0, 8'h00, 8'h08, 1, 3, 8'h00, 8'h00, 1));
        tbl.push_back(mk(8'h0F, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1)); // all pending
        tbl.push_back(mk(8'h1F, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1)); // full
        tbl.push_back(mk(8'h1F, 8'h00, 1, 1, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00, 1)); // pop, still full
        tbl.push_back(mk(8'h1F, 8'h00, 1, 0, 8'h00, 8'h10, 1, 4, 8'h01, 8'h11, 1)); // grant after pop
        tbl.push_back(mk(8'h00, 8'h00, 1, 1, 8'h22, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tbl.push_back(mk(8'h00, 8'h04, 1, 0, 8'h00, 8'h00, 0, 0, 8'h02, 8'h22, 1)); // kill 2 in flight
        tbl.push_back(mk(8'h00, 8'h00, 1, 1, 8'h33, 8'h00, 0, 0, 8'h00, 8'h00, 1)); // dropped
        tbl.push_back(mk(8'h04, 8'h00, 1, 0, 8'h00, 8'h04, 1, 2, 8'h00, 8'h00, 1)); // 2 re-granted
        tbl.push_back(mk(8'h00, 8'h08, 1, 1, 8'h44, 8'h00, 0, 0, 8'h00, 8'h00, 1)); // kill with resp
        tbl.push_back(mk(8'h00, 8'h04, 1, 1, 8'h55, 8'h00, 0, 0, 8'h00, 8'h00, 1)); // kill other owner
        tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 8'h10, 8'h55, 1));
        tbl.push_back(mk(8'h00, 8'h00, 1, 1, 8'h66, 8'h00, 0, 0, 8'h00, 8'h00, 1)); // marked, dropped
        tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h00, 8'h00, 1, 1, 8'h77, 8'h00, 0, 0, 8'h00, 8'h00, 0)); // resp, count 0
        tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h01, 8'h00, 1, 0, 8'h00, 8'h01, 1, 0, 8'h00, 8'h00, 0)); // single fetch
        tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tbl.push_back(mk(8'h00, 8'h00, 1, 1, 8'hAA, 8'h00, 0, 0, 8'h00, 8'h00, 1));
        tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 8'h01, 8'hAA, 1));
        tbl.push_back(mk(8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0));
        tbl.push_back(mk(8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0)); // mem not ready
        tbl.push_back(mk(8'h01, 8'h01, 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0)); // kill blocks req

        for (int r = 0; r < tbl.size(); r++) begin
            v = tbl[r];
            bus.req_i_valid          = v.rv;
            bus.kill_i               = v.kill;
            bus.mem_req_o_ready      = v.mr;
            bus.mem_resp_i_valid     = v.rsp;
            bus.mem_resp_i_bits_data = {64{v.d}};
            @(negedge clk);
            check($sformatf("vec%0d_req_ready", r), 512'(bus.req_i_ready), 512'(v.e_ready));
            check($sformatf("vec%0d_mem_valid", r), 512'(bus.mem_req_o_valid), 512'(v.e_mv));
            if (v.e_mv)
                check($sformatf("vec%0d_mcn", r), 512'(bus.mem_req_o_bits_mcn), 512'(32'h100 + v.e_grant));
            check($sformatf("vec%0d_resp_valid", r), 512'(bus.resp_o_valid), 512'(v.e_rv));
            if (v.e_rv != 8'h00)
                check($sformatf("vec%0d_resp_data", r), bus.resp_o_bits_data, {64{v.e_d}});
            check($sformatf("vec%0d_busy", r), 512'(bus.busy_o), 512'(v.e_busy));
            check($sformatf("vec%0d_resp_ready", r), 512'(bus.mem_resp_i_ready), 512'(1'b1));
            @(posedge clk);
            #1;
        end

        // Async reset with three fetches outstanding (rr_ptr is 1 here)
        drive_idle();
        bus.mem_req_o_ready = 1'b1;
        bus.req_i_valid     = 8'h0E;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("ar_grant%0d", i), 512'(bus.req_i_ready), 512'(8'h01 << i));
            @(posedge clk);
            #1;
        end
        bus.req_i_valid = 8'h00;
        @(negedge clk);
        check("ar_busy_before", 512'(bus.busy_o), 512'(1'b1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 512'(bus.busy_o), 512'(1'b0));
        check("ar_mem_valid", 512'(bus.mem_req_o_valid), 512'(1'b0));
        check("ar_req_ready", 512'(bus.req_i_ready), 512'(8'h00));
        check("ar_resp_valid", 512'(bus.resp_o_valid), 512'(8'h00));
        check("ar_resp_data", bus.resp_o_bits_data, 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_resp_i_valid     = 1'b1;
        bus.mem_resp_i_bits_data = {64{8'hBB}};
        @(negedge clk);
        check("ar_late_resp_busy", 512'(bus.busy_o), 512'(1'b0));
        @(posedge clk);
        #1;
        bus.mem_resp_i_valid = 1'b0;
        bus.req_i_valid      = 8'hFF;
        @(negedge clk);
        check("ar_late_resp_dropped", 512'(bus.resp_o_valid), 512'(8'h00));
        check("ar_first_grant", 512'(bus.req_i_ready), 512'(8'h01));
        @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req_i_valid     = N'($urandom_range(0, 255));
            bus.mem_req_o_ready = ($urandom_range(0, 3) != 0);
            bus.mem_resp_i_valid = ($urandom_range(0, 2) == 0);
            for (int k = 0; k < N; k++) begin
                bus.kill_i[k] = ($urandom_range(0, 15) == 0);
                bus.req_i_bits_mcn[k*MCN_W +: MCN_W] = MCN_W'({$urandom, $urandom});
            end
            for (int w = 0; w < 16; w++) begin
                bus.mem_resp_i_bits_data[w*32 +: 32] = $urandom;
            end
            model_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vlb_mem_arb.md
# vlb_mem_arb

Arbiter and sequencer for the shared memory request channel used by the VLB miss path. It accepts cache-line fetch requests from N requesters (VLB refill walkers), grants one per cycle round-robin onto the single `mem_req_o` port, and tracks up to DEPTH in-flight fetches in an in-order owner FIFO. Each `mem_resp_i` beat is steered back to the owning requester. Requests killed by a VLB flush are dropped on return. It sits between the VLB refill logic and the memory-side port driven by `tb_mem_intf`.

## Interface
- N, 4, number of requesters (2..8)
- DEPTH, 4, maximum outstanding memory fetches; power of two, ≥2
- MCN_W, 58, memory cache-line number width
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_i_valid  in  N  per-requester fetch request
- req_i_ready  out  N  request accepted this cycle
- req_i_bits_mcn  in  N*MCN_W  line number; requester k uses slice [k*MCN_W +: MCN_W]
- kill_i  in  N  abandon requester k's outstanding fetch
- resp_o_valid  out  N  one-hot; line data returned to requester k
- resp_o_bits_data  out  512  returned line, shared by all requesters
- mem_req_o_valid  out  1  fetch to memory
- mem_req_o_ready  in  1  memory accepts fetch
- mem_req_o_bits_mcn  out  MCN_W  granted line number
- mem_resp_i_valid  in  1  memory response beat
- mem_resp_i_ready  out  1  tied to 1
- mem_resp_i_bits_data  in  512  response line
- busy_o  out  1  any fetch in flight or response being delivered

## Operation
- State: pending[N], rr_ptr (log2 N), owner FIFO of DEPTH entries {owner, killed}, wr/rd pointers, count (log2 DEPTH + 1 bits).
- Eligibility: k is eligible when req_i_valid[k] & ~pending[k] & ~kill_i[k].
- Grant: the first eligible k searching rr_ptr, rr_ptr+1, … mod N.
- mem_req_o_valid = any eligible & (count != DEPTH). mem_req_o_bits_mcn = the granted slice.
- req_i_ready[k] = (k == grant) & mem_req_o_valid & mem_req_o_ready. All other bits are 0.
- On fire:
  - push {k, 0}
  - set pending[k]
  - rr_ptr ← (k+1) mod N
- Each requester has at most one fetch outstanding. It cannot re-request until its response returns, even if it was killed.
- Kill: kill_i[k] sets `killed` on the FIFO entry owned by k, if any. Kill with no entry is a no-op.
- Response, when mem_resp_i_valid:
  - pop the head entry and clear pending[head.owner]
  - if head.killed = 0 and kill_i[head.owner] = 0, register resp_o_valid[head.owner] = 1 and resp_o_bits_data = data for the next cycle; otherwise the beat is dropped
- A response with count = 0 is a protocol error. It is discarded with no state change.
- Simultaneous push and pop: count unchanged, both pointers advance. A pop frees a slot only for the next cycle; the full check uses the current count.
- Pointers wrap modulo DEPTH.
- busy_o = (count != 0) | (|resp_o_valid).

## Timing
- Reset (reset = 0, async):
  - pending = 0, rr_ptr = 0, count = 0, wr/rd = 0
  - resp_o_valid = 0, resp_o_bits_data = 0
  - req_i_ready = 0, mem_req_o_valid = 0, busy_o = 0
- Reset asserted mid-operation discards all in-flight fetches. Responses arriving after reset release are protocol errors and are dropped.
- Request path is combinational: req_i → mem_req_o in the same cycle, zero latency.
- Response path: mem_resp_i at cycle t → resp_o_valid at t+1, held one cycle only. No backpressure toward requesters.
- Kill at cycle t:
  - covers a response arriving at t
  - does not retract a resp_o_valid already registered at t
  - a request at t with kill_i[k] = 1 is not granted
- mem_req_o_valid may drop without a fire, e.g. when a requester deasserts valid. Memory must not rely on valid persistence.
- Throughput: 1 grant per cycle; sustained DEPTH in flight.

## Test plan
- Single fetch: req 0, mcn = 0x123, mem ready. Response 0xAA…AA two cycles later → req_i_ready[0] in cycle 0; resp_o_valid = 4'b0001 with data 0xAA…AA one cycle after the response; busy_o low afterwards.
- Round-robin: all 4 valid continuously, mem ready, rr_ptr = 0 → grants 0, 1, 2, 3 in consecutive cycles; each requester is then blocked by pending.
- Full: DEPTH = 4 fetches outstanding plus a 5th requester (N = 8) valid → mem_req_o_valid = 0 until the first response. Grant in the cycle after the pop, not the same cycle.
- Kill in flight: req 2 granted, kill_i[2] pulsed, then response → no resp_o_valid; pending[2] clears; req 2 granted again next.
- Kill coincident with response for the same owner → dropped. Kill for a different owner → that other owner's entry is marked; the head response is delivered.
- Async reset with 3 fetches outstanding → all outputs 0 immediately, count = 0, next grant starts at requester 0.
